// File: rtl/gas_alarm_controller.sv
// Gas alarm controller: windowed per-gas detection counters feeding a four-state
// IDLE/WARN/ALARM/SILENCED FSM with a latched alarm cause and registered outputs.
module gas_alarm_controller #(
  parameter int WINDOW = 200,
  parameter int THRESH = 3
) (
  input  logic       clk,
  input  logic       arst,
  input  logic [2:0] det,
  input  logic       ack,
  output logic [1:0] state,
  output logic       alarm,
  output logic       buzzer,
  output logic [1:0] alarm_src,
  output logic [3:0] ch4_cnt,
  output logic [3:0] co_cnt
);

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    WARN     = 2'b01,
    ALARM    = 2'b10,
    SILENCED = 2'b11
  } state_t;

  localparam logic [7:0] WRAP_C   = 8'(WINDOW - 1);
  localparam logic [3:0] THRESH_C = 4'(THRESH);

  state_t     state_r, state_s;
  logic [7:0] win_cnt_r, win_cnt_s;
  logic [3:0] ch4_cnt_r, co_cnt_r;
  logic [3:0] ch4_inc_s, co_inc_s, ch4_next_s, co_next_s;
  logic [1:0] alarm_src_r, alarm_src_s;
  logic [1:0] over_s, hit_s;
  logic       alarm_r, buzzer_r;
  logic       wrap_s, quiet_s;

  function automatic logic [3:0] sat_inc(input logic [3:0] cnt, input logic hit);
    if (hit && (cnt != 4'd15)) begin
      return cnt + 4'd1;
    end else begin
      return cnt;
    end
  endfunction

  // Window position, per-gas counter updates and threshold qualification
  always_comb begin
    wrap_s     = (win_cnt_r == WRAP_C);
    win_cnt_s  = wrap_s ? 8'd0 : win_cnt_r + 8'd1;
    ch4_inc_s  = sat_inc(ch4_cnt_r, det[0]);
    co_inc_s   = sat_inc(co_cnt_r, det[1]);
    // A wrap restarts each count, keeping only a pulse that lands in the wrap cycle
    ch4_next_s = wrap_s ? {3'b000, det[0]} : ch4_inc_s;
    co_next_s  = wrap_s ? {3'b000, det[1]} : co_inc_s;
    quiet_s    = wrap_s && (ch4_cnt_r == 4'd0) && (co_cnt_r == 4'd0) && (det[1:0] == 2'b00);
    over_s     = {(co_inc_s >= THRESH_C), (ch4_inc_s >= THRESH_C)};
    hit_s      = over_s & det[1:0];
  end

  // Next-state and alarm-cause logic
  always_comb begin
    state_s     = state_r;
    alarm_src_s = alarm_src_r;
    case (state_r)
      IDLE: begin
        if (det[1:0] != 2'b00) begin
          state_s = WARN;
        end else begin
          state_s = IDLE;
        end
      end
      WARN: begin
        if (hit_s != 2'b00) begin
          state_s     = ALARM;
          alarm_src_s = over_s;
        end else if (quiet_s) begin
          state_s = IDLE;
        end else begin
          state_s = WARN;
        end
      end
      ALARM: begin
        // Acknowledge wins over a detection arriving in the same cycle
        if (ack) begin
          state_s = SILENCED;
        end else begin
          state_s = ALARM;
        end
      end
      SILENCED: begin
        if (det[1:0] != 2'b00) begin
          state_s     = ALARM;
          alarm_src_s = alarm_src_r | det[1:0];
        end else if (quiet_s) begin
          state_s     = IDLE;
          alarm_src_s = 2'b00;
        end else begin
          state_s = SILENCED;
        end
      end
      default: begin
        state_s     = IDLE;
        alarm_src_s = 2'b00;
      end
    endcase
  end

  // State, counters and registered outputs
  always_ff @(posedge clk) begin
    if (arst) begin
      state_r     <= IDLE;
      win_cnt_r   <= 8'd0;
      ch4_cnt_r   <= 4'd0;
      co_cnt_r    <= 4'd0;
      alarm_src_r <= 2'b00;
      alarm_r     <= 1'b0;
      buzzer_r    <= 1'b0;
    end else begin
      state_r     <= state_s;
      win_cnt_r   <= win_cnt_s;
      ch4_cnt_r   <= ch4_next_s;
      co_cnt_r    <= co_next_s;
      alarm_src_r <= alarm_src_s;
      alarm_r     <= (state_s == ALARM) || (state_s == SILENCED);
      buzzer_r    <= (state_s == ALARM);
    end
  end

  assign state     = state_r;
  assign alarm     = alarm_r;
  assign buzzer    = buzzer_r;
  assign alarm_src = alarm_src_r;
  assign ch4_cnt   = ch4_cnt_r;
  assign co_cnt    = co_cnt_r;

endmodule

// File: tb/tb_gas_alarm_controller.sv
// Directed self-checking bench for gas_alarm_controller: a WINDOW=16/THRESH=3 instance
// for the FSM scenarios and a WINDOW=32/THRESH=15 instance for counter saturation.
module tb_gas_alarm_controller;

  localparam int W1 = 16;

  logic       clk = 1'b0;
  logic       arst = 1'b1;
  logic [2:0] det = 3'b000;
  logic       ack = 1'b0;
  logic [1:0] state, alarm_src;
  logic       alarm, buzzer;
  logic [3:0] ch4_cnt, co_cnt;

  logic [2:0] det2 = 3'b000;
  logic       ack2 = 1'b0;
  logic [1:0] state2, alarm_src2;
  logic       alarm2, buzzer2;
  logic [3:0] ch4_cnt2, co_cnt2;

  int checks = 0;
  int errors = 0;
  int wc = 0;

  always #5 clk = ~clk;

  gas_alarm_controller #(.WINDOW(16), .THRESH(3)) u1 (
    .clk(clk), .arst(arst), .det(det), .ack(ack), .state(state), .alarm(alarm),
    .buzzer(buzzer), .alarm_src(alarm_src), .ch4_cnt(ch4_cnt), .co_cnt(co_cnt)
  );

  gas_alarm_controller #(.WINDOW(32), .THRESH(15)) u2 (
    .clk(clk), .arst(arst), .det(det2), .ack(ack2), .state(state2), .alarm(alarm2),
    .buzzer(buzzer2), .alarm_src(alarm_src2), .ch4_cnt(ch4_cnt2), .co_cnt(co_cnt2)
  );

  // wc mirrors u1's window position during the cycle following each edge
  task automatic tick();
    @(posedge clk);
    #1;
    if (arst) wc = 0;
    else if (wc == W1 - 1) wc = 0;
    else wc = wc + 1;
  endtask

  task automatic wait_wc(input int n);
    int guard = 0;
    while (wc != n && guard < 2 * W1) begin
      tick();
      guard++;
    end
    checks++;
    if (wc != n) begin
      errors++;
      $display("FAIL wait_wc: window position %0d, wanted %0d", wc, n);
    end
  endtask

  task automatic pulse(input logic [2:0] d);
    det = d;
    tick();
    det = 3'b000;
  endtask

  task automatic do_reset();
    arst = 1'b1;
    tick();
    tick();
    arst = 1'b0;
  endtask

  task automatic test_reset();
    arst = 1'b1; det = 3'b011; ack = 1'b1;
    tick();
    tick();
    checks++; if (state !== 2'b00) begin errors++; $display("FAIL reset_state: got %b want 00", state); end
    checks++; if (alarm !== 1'b0) begin errors++; $display("FAIL reset_alarm: got %b want 0", alarm); end
    checks++; if (buzzer !== 1'b0) begin errors++; $display("FAIL reset_buzzer: got %b want 0", buzzer); end
    checks++; if (alarm_src !== 2'b00) begin errors++; $display("FAIL reset_src: got %b want 00", alarm_src); end
    checks++; if (ch4_cnt !== 4'd0) begin errors++; $display("FAIL reset_ch4: got %0d want 0", ch4_cnt); end
    checks++; if (co_cnt !== 4'd0) begin errors++; $display("FAIL reset_co: got %0d want 0", co_cnt); end
    arst = 1'b0; det = 3'b000;
    tick();
    checks++; if (state !== 2'b00) begin errors++; $display("FAIL ack_in_idle: got %b want 00", state); end
    ack = 1'b0;
    pulse(3'b100);
    checks++; if (state !== 2'b00 || ch4_cnt !== 4'd0 || co_cnt !== 4'd0) begin
      errors++; $display("FAIL det2_ignored: state %b ch4 %0d co %0d want 00/0/0", state, ch4_cnt, co_cnt);
    end
  endtask

  task automatic test_warn_alarm();
    do_reset();
    wait_wc(2);
    pulse(3'b001);
    checks++; if (state !== 2'b01) begin errors++; $display("FAIL first_pulse_warn: got %b want 01", state); end
    wait_wc(5);
    pulse(3'b001);
    checks++; if (state !== 2'b01 || ch4_cnt !== 4'd2) begin
      errors++; $display("FAIL second_pulse: state %b ch4 %0d want 01/2", state, ch4_cnt);
    end
    wait_wc(8);
    pulse(3'b001);
    checks++; if (state !== 2'b10) begin errors++; $display("FAIL third_pulse_alarm: got %b want 10", state); end
    checks++; if (buzzer !== 1'b1 || alarm !== 1'b1) begin
      errors++; $display("FAIL alarm_outputs: buzzer %b alarm %b want 1/1", buzzer, alarm);
    end
    checks++; if (alarm_src !== 2'b01) begin errors++; $display("FAIL alarm_src_ch4: got %b want 01", alarm_src); end
    checks++; if (ch4_cnt !== 4'd3) begin errors++; $display("FAIL ch4_at_alarm: got %0d want 3", ch4_cnt); end
  endtask

  task automatic test_silence();
    ack = 1'b1;
    tick();
    ack = 1'b0;
    checks++; if (state !== 2'b11 || buzzer !== 1'b0 || alarm !== 1'b1) begin
      errors++; $display("FAIL silence: state %b buzzer %b alarm %b want 11/0/1", state, buzzer, alarm);
    end
    pulse(3'b010);
    checks++; if (state !== 2'b10 || alarm_src !== 2'b11 || buzzer !== 1'b1) begin
      errors++; $display("FAIL realarm: state %b src %b buzzer %b want 10/11/1", state, alarm_src, buzzer);
    end
  endtask

  task automatic test_quiet_wrap();
    do_reset();
    wait_wc(3);
    pulse(3'b010);
    pulse(3'b010);
    checks++; if (state !== 2'b01 || co_cnt !== 4'd2) begin
      errors++; $display("FAIL co_warn: state %b co %0d want 01/2", state, co_cnt);
    end
    wait_wc(15);
    tick();
    checks++; if (co_cnt !== 4'd0 || state !== 2'b01) begin
      errors++; $display("FAIL busy_wrap: co %0d state %b want 0/01", co_cnt, state);
    end
    wait_wc(15);
    tick();
    checks++; if (state !== 2'b00) begin errors++; $display("FAIL quiet_wrap_idle: got %b want 00", state); end
  endtask

  task automatic test_wrap_load();
    do_reset();
    wait_wc(15);
    pulse(3'b001);
    checks++; if (ch4_cnt !== 4'd1) begin errors++; $display("FAIL wrap_load: ch4 %0d want 1", ch4_cnt); end
    checks++; if (state !== 2'b01) begin errors++; $display("FAIL wrap_load_state: got %b want 01", state); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 20; i++) begin
      det2 = 3'b010;
      tick();
    end
    det2 = 3'b000;
    checks++; if (co_cnt2 !== 4'd15) begin errors++; $display("FAIL co_saturate: got %0d want 15", co_cnt2); end
    checks++; if (state2 !== 2'b10 || alarm_src2 !== 2'b10) begin
      errors++; $display("FAIL thresh15_alarm: state %b src %b want 10/10", state2, alarm_src2);
    end
    checks++; if (ch4_cnt2 !== 4'd0) begin errors++; $display("FAIL ch4_untouched: got %0d want 0", ch4_cnt2); end
  endtask

  task automatic test_ack_priority();
    do_reset();
    pulse(3'b001);
    pulse(3'b001);
    pulse(3'b001);
    checks++; if (state !== 2'b10) begin errors++; $display("FAIL b2b_alarm: got %b want 10", state); end
    ack = 1'b1; det = 3'b001;
    tick();
    ack = 1'b0; det = 3'b000;
    checks++; if (state !== 2'b11) begin errors++; $display("FAIL ack_priority: got %b want 11", state); end
    for (int i = 0; i < 2 * W1; i++) tick();
    checks++; if (state !== 2'b00 || alarm_src !== 2'b00 || alarm !== 1'b0) begin
      errors++; $display("FAIL silenced_timeout: state %b src %b alarm %b want 00/00/0", state, alarm_src, alarm);
    end
  endtask

  initial begin
    test_reset();
    test_warn_alarm();
    test_silence();
    test_quiet_wrap();
    test_wrap_load();
    test_back_to_back();
    test_ack_priority();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gas_alarm_controller.md
GAS_ALARM_CONTROLLER -- requirements
Module: gas_alarm_controller

Interface
REQ-001 SHALL have parameter WINDOW, default 200: observation window length in clk cycles (legal 2..256).
REQ-002 SHALL have parameter THRESH, default 3: detections per gas within one window that raise an alarm (legal 1..15).
REQ-003 SHALL have port clk  input  1  system clock, all logic on posedge.
REQ-004 SHALL have port arst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port det  input  3  one-cycle detection flags from the upstream detector: bit0 methane, bit1 CO, bit2 reserved.
REQ-006 SHALL have port ack  input  1  operator acknowledge, level-sampled each cycle.
REQ-007 SHALL have port state  output  2  FSM state: 00 IDLE, 01 WARN, 10 ALARM, 11 SILENCED.
REQ-008 SHALL have port alarm  output  1  high in ALARM or SILENCED.
REQ-009 SHALL have port buzzer  output  1  high only in ALARM.
REQ-010 SHALL have port alarm_src  output  2  latched alarm cause: bit0 methane, bit1 CO.
REQ-011 SHALL have port ch4_cnt  output  4  methane detections in the current window.
REQ-012 SHALL have port co_cnt  output  4  CO detections in the current window.

Function
REQ-013 SHALL drive all outputs from registers; alarm and buzzer SHALL be decoded from the next-state value so they change in the same cycle as state.
REQ-014 SHALL ignore det[2] in every state.
REQ-015 SHALL run 8-bit win_cnt freely from 0 to WINDOW-1 and wrap to 0; the wrap cycle is the cycle with win_cnt==WINDOW-1.
REQ-016 SHALL increment ch4_cnt on det[0] and co_cnt on det[1], saturating at 15.
REQ-017 SHALL load each counter in the cycle after a wrap with 1 if its det bit was high in the wrap cycle, else 0.
REQ-018 SHALL define "quiet wrap" as a wrap cycle with ch4_cnt==0, co_cnt==0 and det[1:0]==00.
REQ-019 SHALL move IDLE->WARN on any det[1:0] bit high; IDLE otherwise holds.
REQ-020 SHALL move WARN->ALARM when either incremented count reaches THRESH; alarm_src SHALL load the set of gases at or above THRESH.
REQ-021 SHALL move WARN->IDLE on a quiet wrap; otherwise hold WARN.
REQ-022 SHALL move ALARM->SILENCED when ack=1, with ack taking priority over a simultaneous det pulse; ALARM otherwise holds.
REQ-023 SHALL move SILENCED->ALARM on any det[1:0] bit high, ORing the pulsing gas bits into alarm_src.
REQ-024 SHALL move SILENCED->IDLE on a quiet wrap and clear alarm_src in the same transition.
REQ-025 SHALL ignore ack outside ALARM.
REQ-026 SHALL keep counters and win_cnt running identically in all states.
REQ-027 SHALL, with THRESH=1, move IDLE->WARN and then WARN->ALARM on the first and second qualifying edges, because IDLE never goes directly to ALARM.

Reset
REQ-028 SHALL, while arst=1 at a clk edge, force state=IDLE, win_cnt=0, ch4_cnt=0, co_cnt=0, alarm_src=00, alarm=0 and buzzer=0, overriding det and ack.
REQ-029 SHALL, on arst asserted mid-ALARM, reach the REQ-028 values at the next edge and start win_cnt from 0 on the first cycle after release.

Verification (bench uses WINDOW=16, THRESH=3)
REQ-030 SHALL check: arst=1 for 2 cycles with det=011 and ack=1 -> all outputs 0 and state=00.
REQ-031 SHALL check: det[0] pulses at win_cnt 2, 5 and 8 -> state=01 after the first pulse; after the third, state=10, buzzer=1, alarm_src=01 and ch4_cnt=3.
REQ-032 SHALL check: ack=1 in ALARM -> state=11, buzzer=0, alarm=1; a later det[1] pulse -> state=10 and alarm_src=11.
REQ-033 SHALL check: det[1] pulses at win_cnt 3 and 4 only -> WARN; after wrap at 15, co_cnt=0; at the next wrap, state=00.
REQ-034 SHALL check: det[0] pulse in the wrap cycle -> ch4_cnt=1 on the following cycle; 20 CO pulses with THRESH=15 and WINDOW=32 -> co_cnt holds at 15.
REQ-035 SHALL check: ack=1 together with det=001 in ALARM -> state=11; in SILENCED, det=000 for two full windows -> state=00 and alarm_src=00.
